time_count_chain: RTL and testbench

- Consumer end of the clock-fix path: it receives the hour, minute and second advance strobes produced by the mode/turn/change selection logic.
- It keeps the BCD time-of-day in three counters: seconds 00-59, minutes 00-59 and hours 00-HOUR_MAX.
- It returns the wrap carries s_bit and m_bit that the selection logic routes back as minute/hour advances in run mode.
- Fully synchronous: the incoming strobes are treated as data, synchronised and rising-edge detected, never used as clocks.

---
 rtl/clock_pkg.sv | 33 +++
 rtl/bcd_field_counter.sv | 80 ++++++++
 rtl/time_count_chain.sv | 55 +++++
 tb/tb_time_count_chain.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the BCD time-of-day counter chain.
// Field helpers are pure functions so every counter instance uses the same arithmetic.
package clock_pkg;

    typedef logic [3:0] digit_t;
    typedef logic [7:0] field_t;

    localparam field_t      SEC_MAX          = 8'h59;
    localparam field_t      MIN_MAX          = 8'h59;
    localparam int unsigned HOUR_MAX_DEFAULT = 23;

    // Binary 0..99 to packed BCD {tens, ones}.
    function automatic field_t to_bcd(input int unsigned v);
        digit_t tens;
        digit_t ones;
        tens = digit_t'(v / 10);
        ones = digit_t'(v % 10);
        return {tens, ones};
    endfunction

    // Plain BCD +1 with ones carry; the field wrap is handled by the caller.
    function automatic field_t bcd_inc(input field_t v);
        digit_t tens;
        digit_t ones;
        tens = v[7:4];
        ones = v[3:0];
        if (ones == 4'd9) begin
            return {tens + 4'd1, 4'd0};
        end
        return {tens, ones + 4'd1};
    endfunction

endpackage

// File: rtl/bcd_field_counter.sv
// One BCD time field: strobe synchroniser, rising-edge detect, BCD increment with a
// configurable wrap value and a registered one-cycle wrap pulse.
module bcd_field_counter
    import clock_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter field_t      WRAP_VAL    = SEC_MAX
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   strobe,
    output field_t count,
    output logic   wrap
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] vld_q, vld_d;
    logic                   prev_q, prev_d;
    logic                   armed_q, armed_d;
    field_t                 count_q, count_d;
    logic                   wrap_q, wrap_d;

    logic sync_out;
    logic inc;

    always_comb begin
        sync_d    = '0;
        vld_d     = '0;
        sync_d[0] = strobe;
        vld_d[0]  = 1'b1;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
            vld_d[i]  = vld_q[i-1];
        end
    end

    // vld_q tracks when the chain holds real post-reset samples; a strobe only counts
    // once it has been seen low after reset, so a level held across reset is ignored.
    always_comb begin
        sync_out = sync_q[SYNC_STAGES-1];
        prev_d   = sync_out;
        armed_d  = armed_q | (vld_q[SYNC_STAGES-1] & ~sync_out);
        inc      = armed_q & sync_out & ~prev_q;
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (inc) begin
            if (count_q == WRAP_VAL) begin
                count_d = '0;
                wrap_d  = 1'b1;
            end else begin
                count_d = bcd_inc(count_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= '0;
            vld_q   <= '0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            vld_q   <= vld_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;

endmodule

// File: rtl/time_count_chain.sv
// Hour/minute/second BCD counters driven by externally selected advance strobes.
// Fields are independent; chaining is done upstream by feeding s_bit/m_bit back.
module time_count_chain
    import clock_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOUR_MAX    = HOUR_MAX_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_s,
    input  logic       clk_m,
    input  logic       clk_h,
    output logic [7:0] sec,
    output logic [7:0] min,
    output logic [7:0] hour,
    output logic       s_bit,
    output logic       m_bit,
    output logic       h_wrap
);

    bcd_field_counter #(
        .SYNC_STAGES (SYNC_STAGES),
        .WRAP_VAL    (SEC_MAX)
    ) u_sec (
        .clk    (clk),
        .rst_n  (rst_n),
        .strobe (clk_s),
        .count  (sec),
        .wrap   (s_bit)
    );

    bcd_field_counter #(
        .SYNC_STAGES (SYNC_STAGES),
        .WRAP_VAL    (MIN_MAX)
    ) u_min (
        .clk    (clk),
        .rst_n  (rst_n),
        .strobe (clk_m),
        .count  (min),
        .wrap   (m_bit)
    );

    bcd_field_counter #(
        .SYNC_STAGES (SYNC_STAGES),
        .WRAP_VAL    (to_bcd(HOUR_MAX))
    ) u_hour (
        .clk    (clk),
        .rst_n  (rst_n),
        .strobe (clk_h),
        .count  (hour),
        .wrap   (h_wrap)
    );

endmodule

// File: tb/tb_time_count_chain.sv
// Directed bench for time_count_chain with a run-mode loopback model of the selection logic.
module tb_time_count_chain;

    logic       clk;
    logic       rst_n;
    logic       clk_s;
    logic       clk_m_man;
    logic       clk_h_man;
    logic       loop_en;
    logic       clk_m;
    logic       clk_h;
    logic [7:0] sec;
    logic [7:0] min;
    logic [7:0] hour;
    logic       s_bit;
    logic       m_bit;
    logic       h_wrap;

    int n_tests;
    int n_fail;

    // Selection logic in run mode routes carries back as the next field's strobe.
    assign clk_m = loop_en ? s_bit : clk_m_man;
    assign clk_h = loop_en ? m_bit : clk_h_man;

    time_count_chain #(
        .SYNC_STAGES (2),
        .HOUR_MAX    (23)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_s  (clk_s),
        .clk_m  (clk_m),
        .clk_h  (clk_h),
        .sec    (sec),
        .min    (min),
        .hour   (hour),
        .s_bit  (s_bit),
        .m_bit  (m_bit),
        .h_wrap (h_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Each selected strobe goes high for two cycles then low for two; the count has
    // settled by the time the task returns.
    task automatic strobe(input logic s, input logic m, input logic h);
        clk_s     = s;
        clk_m_man = m;
        clk_h_man = h;
        tick(2);
        clk_s     = 1'b0;
        clk_m_man = 1'b0;
        clk_h_man = 1'b0;
        tick(2);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        clk_s     = 1'b1;
        clk_m_man = 1'b0;
        clk_h_man = 1'b0;
        loop_en   = 1'b0;

        // Reset held with clk_s high.
        tick(3);
        check("rst_sec", sec, 8'h00);
        check("rst_min", min, 8'h00);
        check("rst_hour", hour, 8'h00);
        check("rst_carries", {5'b0, s_bit, m_bit, h_wrap}, 8'h00);

        // Release with clk_s still high: must not count.
        rst_n = 1'b1;
        tick(6);
        check("rel_high_no_inc", sec, 8'h00);
        clk_s = 1'b0;
        tick(4);

        // Latency: strobe rises just after edge T, count changes at edge T+3.
        clk_s = 1'b1;
        tick(2);
        check("lat_t2", sec, 8'h00);
        tick(1);
        check("lat_t3", sec, 8'h01);
        check("lat_sbit", {7'b0, s_bit}, 8'h00);
        clk_s = 1'b0;
        tick(2);

        // BCD digit roll.
        repeat (8) strobe(1'b1, 1'b0, 1'b0);
        check("roll_09", sec, 8'h09);
        strobe(1'b1, 1'b0, 1'b0);
        check("roll_10", sec, 8'h10);
        repeat (49) strobe(1'b1, 1'b0, 1'b0);
        check("sec_59", sec, 8'h59);

        // Seconds wrap with a single-cycle carry.
        clk_s = 1'b1;
        tick(3);
        check("wrap_sec", sec, 8'h00);
        check("wrap_sbit_hi", {7'b0, s_bit}, 8'h01);
        clk_s = 1'b0;
        tick(1);
        check("wrap_sbit_lo", {7'b0, s_bit}, 8'h00);
        tick(2);

        // Drive all three fields to 23:59:59, mostly with simultaneous edges.
        for (int i = 0; i < 59; i++) begin
            strobe(1'b1, 1'b1, (i < 23));
            if (i == 19) check("hour_19_20", hour, 8'h20);
        end
        check("pre_sec", sec, 8'h59);
        check("pre_min", min, 8'h59);
        check("pre_hour", hour, 8'h23);

        // Loopback: one seconds edge ripples through to a day rollover.
        loop_en = 1'b1;
        clk_s   = 1'b1;
        tick(3);
        check("lb_sec", sec, 8'h00);
        check("lb_sbit", {7'b0, s_bit}, 8'h01);
        clk_s = 1'b0;
        tick(3);
        check("lb_min", min, 8'h00);
        check("lb_mbit", {7'b0, m_bit}, 8'h01);
        check("lb_hour_hold", hour, 8'h23);
        tick(1);
        check("lb_mbit_lo", {7'b0, m_bit}, 8'h00);
        tick(2);
        check("lb_hour", hour, 8'h00);
        check("lb_hwrap", {7'b0, h_wrap}, 8'h01);
        tick(1);
        check("lb_hwrap_lo", {7'b0, h_wrap}, 8'h00);
        tick(8);
        check("lb_final", {sec | min | hour}, 8'h00);
        check("lb_final_carries", {5'b0, s_bit, m_bit, h_wrap}, 8'h00);
        loop_en = 1'b0;

        // 12:34 then simultaneous minute and hour edges.
        for (int i = 0; i < 34; i++) strobe(1'b0, 1'b1, (i < 12));
        check("pre_sim_min", min, 8'h34);
        check("pre_sim_hour", hour, 8'h12);
        strobe(1'b0, 1'b1, 1'b1);
        check("sim_min", min, 8'h35);
        check("sim_hour", hour, 8'h13);
        check("sim_sec", sec, 8'h00);

        // Reset while a clk_s edge is in the synchroniser.
        clk_s = 1'b1;
        tick(1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("mid_rst_sec", sec, 8'h00);
        check("mid_rst_min", min, 8'h00);
        check("mid_rst_hour", hour, 8'h00);
        tick(6);
        check("mid_rst_no_inc", sec, 8'h00);
        clk_s = 1'b0;
        tick(4);
        strobe(1'b1, 1'b0, 1'b0);
        check("post_rst_inc", sec, 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
